fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 206 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word-aligned fetches, tags them with their PC,
// buffers responses in a 2-entry FIFO for decode and discards stale responses after a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_valid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    input  logic        i_inst_ready
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [31:0] pc_r;
    logic [1:0]  inflight_r;
    logic [1:0]  drop_r;
    logic [1:0]  tag_cnt_r;
    logic [31:0] tag0_r;
    logic [31:0] tag1_r;
    logic        fifo_v0_r;
    logic        fifo_v1_r;
    logic [31:0] fifo_inst0_r;
    logic [31:0] fifo_pc0_r;
    logic [31:0] fifo_inst1_r;
    logic [31:0] fifo_pc1_r;

    logic [1:0]  fifo_count_s;
    logic [2:0]  occupancy_s;
    logic        accept_s;
    logic        resp_s;
    logic        resp_drop_s;
    logic        resp_keep_s;
    logic        pop_s;
    logic        unused_s;

    logic [31:0] pc_next_s;
    logic [1:0]  inflight_next_s;
    logic [1:0]  drop_next_s;
    logic [1:0]  tag_cnt_next_s;
    logic [31:0] tag0_next_s;
    logic [31:0] tag1_next_s;
    logic        fifo_v0_next_s;
    logic        fifo_v1_next_s;
    logic [31:0] fifo_inst0_next_s;
    logic [31:0] fifo_pc0_next_s;
    logic [31:0] fifo_inst1_next_s;
    logic [31:0] fifo_pc1_next_s;

    // The low redirect bits carry no information for a word-aligned fetch.
    assign unused_s = ^i_redirect_pc[1:0];

    // Request gating and event decode for this cycle.
    always_comb begin
        fifo_count_s = {1'b0, fifo_v0_r} + {1'b0, fifo_v1_r};
        occupancy_s  = {1'b0, inflight_r} + {1'b0, fifo_count_s};
        o_imem_req   = (!i_rst) && (!i_redirect) && (occupancy_s < 3'd2);
        o_imem_addr  = pc_r;
        accept_s     = o_imem_req && i_imem_ready;
        // Responses with nothing outstanding (e.g. after reset) are ignored entirely.
        resp_s       = i_imem_valid && (inflight_r != 2'd0);
        resp_drop_s  = resp_s && (drop_r != 2'd0);
        resp_keep_s  = resp_s && (drop_r == 2'd0);
        pop_s        = fifo_v0_r && i_inst_ready;
    end

    // Next PC, outstanding-request counter and drop counter.
    always_comb begin
        pc_next_s       = pc_r;
        inflight_next_s = inflight_r;
        drop_next_s     = drop_r;
        if (i_redirect) begin
            pc_next_s = {i_redirect_pc[31:2], 2'b00};
        end else if (accept_s) begin
            pc_next_s = pc_r + 32'd4;
        end else begin
            pc_next_s = pc_r;
        end
        if (accept_s && !resp_s) begin
            inflight_next_s = inflight_r + 2'd1;
        end else if (!accept_s && resp_s) begin
            inflight_next_s = inflight_r - 2'd1;
        end else begin
            inflight_next_s = inflight_r;
        end
        // Every request still outstanding after this cycle belongs to the old path.
        if (i_redirect) begin
            drop_next_s = resp_s ? (inflight_r - 2'd1) : inflight_r;
        end else if (resp_drop_s) begin
            drop_next_s = drop_r - 2'd1;
        end else begin
            drop_next_s = drop_r;
        end
    end

    // In-order PC tag queue: slot 0 is always the oldest outstanding kept request.
    always_comb begin
        tag_cnt_next_s = tag_cnt_r;
        tag0_next_s    = tag0_r;
        tag1_next_s    = tag1_r;
        if (i_redirect) begin
            tag_cnt_next_s = 2'd0;
        end else begin
            if (resp_keep_s) begin
                tag0_next_s    = tag1_r;
                tag_cnt_next_s = tag_cnt_r - 2'd1;
            end else begin
                tag_cnt_next_s = tag_cnt_r;
            end
            if (accept_s) begin
                if (tag_cnt_next_s == 2'd0) begin
                    tag0_next_s = pc_r;
                end else begin
                    tag1_next_s = pc_r;
                end
                tag_cnt_next_s = tag_cnt_next_s + 2'd1;
            end else begin
                tag1_next_s = tag1_next_s;
            end
        end
    end

    // Output FIFO: slot 0 is the head and drives the decode outputs directly.
    always_comb begin
        fifo_v0_next_s    = fifo_v0_r;
        fifo_v1_next_s    = fifo_v1_r;
        fifo_inst0_next_s = fifo_inst0_r;
        fifo_pc0_next_s   = fifo_pc0_r;
        fifo_inst1_next_s = fifo_inst1_r;
        fifo_pc1_next_s   = fifo_pc1_r;
        if (i_redirect) begin
            fifo_v0_next_s = 1'b0;
            fifo_v1_next_s = 1'b0;
        end else begin
            if (pop_s) begin
                fifo_v0_next_s = fifo_v1_r;
                fifo_v1_next_s = 1'b0;
                if (fifo_v1_r) begin
                    fifo_inst0_next_s = fifo_inst1_r;
                    fifo_pc0_next_s   = fifo_pc1_r;
                end else begin
                    fifo_inst0_next_s = fifo_inst0_r;
                end
            end else begin
                fifo_v1_next_s = fifo_v1_r;
            end
            if (resp_keep_s) begin
                if (!fifo_v0_next_s) begin
                    fifo_v0_next_s    = 1'b1;
                    fifo_inst0_next_s = i_imem_rdata;
                    fifo_pc0_next_s   = tag0_r;
                end else begin
                    fifo_v1_next_s    = 1'b1;
                    fifo_inst1_next_s = i_imem_rdata;
                    fifo_pc1_next_s   = tag0_r;
                end
            end else begin
                fifo_v1_next_s = fifo_v1_next_s;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_r         <= {RESET_ADDR[31:2], 2'b00};
            inflight_r   <= 2'd0;
            drop_r       <= 2'd0;
            tag_cnt_r    <= 2'd0;
            tag0_r       <= 32'h0000_0000;
            tag1_r       <= 32'h0000_0000;
            fifo_v0_r    <= 1'b0;
            fifo_v1_r    <= 1'b0;
            fifo_inst0_r <= NOP_INST;
            fifo_pc0_r   <= RESET_ADDR;
            fifo_inst1_r <= NOP_INST;
            fifo_pc1_r   <= RESET_ADDR;
        end else begin
            pc_r         <= pc_next_s;
            inflight_r   <= inflight_next_s;
            drop_r       <= drop_next_s;
            tag_cnt_r    <= tag_cnt_next_s;
            tag0_r       <= tag0_next_s;
            tag1_r       <= tag1_next_s;
            fifo_v0_r    <= fifo_v0_next_s;
            fifo_v1_r    <= fifo_v1_next_s;
            fifo_inst0_r <= fifo_inst0_next_s;
            fifo_pc0_r   <= fifo_pc0_next_s;
            fifo_inst1_r <= fifo_inst1_next_s;
            fifo_pc1_r   <= fifo_pc1_next_s;
        end
    end

    assign o_inst_valid = fifo_v0_r;
    assign o_inst       = fifo_inst0_r;
    assign o_inst_pc    = fifo_pc0_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a small in-order memory model feeds responses,
// every accepted fetch is queued as expected decode output and checked on consumption.
module tb_fetch_stage;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam logic [31:0] NOP_INST   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_valid;
    logic [31:0] i_imem_rdata;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_inst_valid;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        i_inst_ready;

    typedef struct {
        logic [31:0] addr;
        bit          live;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] cons_q[$];
    logic [31:0] pc_m;
    int          checks = 0;
    int          errors = 0;
    bit          resp_en = 1'b1;
    bit          rand_mode = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_ADDR(RESET_ADDR)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_valid(i_imem_valid), .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_inst_valid(o_inst_valid), .o_inst(o_inst), .o_inst_pc(o_inst_pc),
        .i_inst_ready(i_inst_ready)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        word_of = {a[7:0], a[31:8]} ^ 32'hC3A5_0F01;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cons_at(input int idx);
        cons_at = (cons_q.size() > idx) ? cons_q[idx] : 32'hFFFF_FFFF;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle once inputs are stable.
    always @(negedge clk) begin : mon
        int   live_n;
        int   fifo_m;
        logic exp_req;
        if (i_rst) begin
            check_eq("rst_req", {31'b0, o_imem_req}, 32'd0);
            check_eq("rst_valid", {31'b0, o_inst_valid}, 32'd0);
            mem_q.delete();
            exp_q.delete();
            pc_m = {RESET_ADDR[31:2], 2'b00};
        end else begin
            live_n = 0;
            foreach (mem_q[k]) if (mem_q[k].live) live_n++;
            fifo_m  = exp_q.size() - live_n;
            exp_req = !i_redirect && ((mem_q.size() + fifo_m) < 2);
            check_eq("req", {31'b0, o_imem_req}, {31'b0, exp_req});
            check_eq("addr", o_imem_addr, pc_m);
            if (exp_q.size() == 0)
                check_eq("spurious_valid", {31'b0, o_inst_valid}, 32'd0);
            if (o_inst_valid && i_inst_ready && exp_q.size() > 0) begin
                check_eq("inst_pc", o_inst_pc, exp_q[0]);
                check_eq("inst_word", o_inst, word_of(exp_q[0]));
                cons_q.push_back(o_inst_pc);
                void'(exp_q.pop_front());
            end
            if (i_imem_valid && mem_q.size() > 0)
                void'(mem_q.pop_front());
            if (i_redirect) begin
                exp_q.delete();
                foreach (mem_q[k]) mem_q[k].live = 1'b0;
                pc_m = {i_redirect_pc[31:2], 2'b00};
            end else if (exp_req && i_imem_ready) begin
                mem_q.push_back('{addr: pc_m, live: 1'b1});
                exp_q.push_back(pc_m);
                pc_m = pc_m + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        i_redirect = 1'b0;
        if (rand_mode) begin
            i_imem_ready = 1'($urandom_range(0, 1));
            i_inst_ready = 1'($urandom_range(0, 1));
            resp_en      = ($urandom_range(0, 3) != 0);
        end
        i_imem_valid = resp_en && (mem_q.size() > 0) && !i_rst;
        i_imem_rdata = i_imem_valid ? word_of(mem_q[0].addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        int mark;
        bit found;
        i_rst = 1'b1; i_imem_ready = 1'b1; i_imem_valid = 1'b0; i_imem_rdata = 32'h0;
        i_redirect = 1'b0; i_redirect_pc = 32'h0; i_inst_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_inst", o_inst, NOP_INST);
        check_eq("rst_inst_pc", o_inst_pc, RESET_ADDR);
        check_eq("rst_addr", o_imem_addr, RESET_ADDR);
        i_rst = 1'b0;
        #1;
        check_eq("first_req", {31'b0, o_imem_req}, 32'd1);

        // Straight-line fetch with 1-cycle memory.
        repeat (12) tick();
        check_eq("seq0", cons_at(0), 32'h0);
        check_eq("seq1", cons_at(1), 32'h4);
        check_eq("seq2", cons_at(2), 32'h8);

        // Decode stalls: FIFO fills to two entries and requests stop.
        i_inst_ready = 1'b0;
        repeat (8) tick();
        #1;
        check_eq("stall_req", {31'b0, o_imem_req}, 32'd0);
        check_eq("stall_valid", {31'b0, o_inst_valid}, 32'd1);
        mark = cons_q.size();
        i_inst_ready = 1'b1;
        repeat (6) tick();
        check_eq("drain_cnt_ge2", {31'b0, cons_q.size() >= mark + 2}, 32'd1);

        // Two requests in flight at 0x10/0x14, then redirect to 0x103.
        resp_en = 1'b0;
        tick(); i_redirect = 1'b1; i_redirect_pc = 32'h10;
        tick(); tick(); tick();
        #1;
        check_eq("two_inflight_addr", o_imem_addr, 32'h18);
        i_redirect = 1'b1; i_redirect_pc = 32'h103;
        mark = cons_q.size();
        resp_en = 1'b1;
        tick();
        check_eq("redir_addr", o_imem_addr, 32'h100);
        repeat (10) tick();
        check_eq("redir_first_pc", cons_at(mark), 32'h100);

        // Redirect coinciding with a response and a decode pop.
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (o_inst_valid && i_imem_valid) begin
                i_redirect = 1'b1; i_redirect_pc = 32'h200; found = 1'b1;
            end
        end
        check_eq("coincide_found", {31'b0, found}, 32'd1);
        mark = cons_q.size() + (o_inst_valid ? 1 : 0);
        tick();
        check_eq("coincide_addr", o_imem_addr, 32'h200);
        repeat (8) tick();
        check_eq("coincide_first_pc", cons_at(mark), 32'h200);

        // Address wrap at the top of the space.
        tick(); i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
        tick();
        check_eq("wrap_top", o_imem_addr, 32'hFFFF_FFFC);
        for (int n = 0; n < 10 && o_imem_addr == 32'hFFFF_FFFC; n++) tick();
        check_eq("wrap_addr", o_imem_addr, 32'h0);

        // Random handshakes and redirects.
        rand_mode = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if ($urandom_range(0, 15) == 0) begin
                i_redirect = 1'b1; i_redirect_pc = $urandom;
            end
        end
        rand_mode = 1'b0; i_imem_ready = 1'b1; i_inst_ready = 1'b1; resp_en = 1'b1;
        repeat (10) tick();

        // Reset with requests in flight, then stray responses.
        resp_en = 1'b0;
        tick(); i_redirect = 1'b1; i_redirect_pc = 32'h40;
        repeat (4) tick();
        i_rst = 1'b1;
        tick(); i_imem_valid = 1'b1; i_imem_rdata = 32'h1111_2222;
        tick(); i_imem_valid = 1'b1; i_imem_rdata = 32'h3333_4444;
        tick();
        i_rst = 1'b0; resp_en = 1'b1;
        i_imem_valid = 1'b1; i_imem_rdata = 32'h5555_6666;
        mark = cons_q.size();
        #1;
        check_eq("post_rst_addr", o_imem_addr, RESET_ADDR);
        check_eq("post_rst_valid", {31'b0, o_inst_valid}, 32'd0);
        tick();
        check_eq("post_rst_stray_valid", {31'b0, o_inst_valid}, 32'd0);
        repeat (8) tick();
        check_eq("post_rst_first_pc", cons_at(mark), RESET_ADDR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
